// File: rtl/avalon_master_pkg.sv
// +------------------------------------------------------------------+
// | avalon_master_pkg: shared types and default sizes for the         |
// | Avalon-MM master adapter.                          Rev 1.0        |
// +------------------------------------------------------------------+
`default_nettype none

package avalon_master_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam int c_DEF_ADDRESSWIDTH    = 16;
    localparam int c_DEF_BUSWIDTH        = 32;
    localparam int c_DEF_MAX_OUTSTANDING = 4;
    localparam int c_DEF_TIMEOUT         = 256;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +------------------------------------------------------------------+
// | sync_fifo: single-clock FIFO, registered storage, no fall-through.|
// |                                                    Rev 1.0        |
// +------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_rd_data
);

    localparam int c_PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNTW = $clog2(DEPTH + 1);
    localparam logic [c_CNTW-1:0] c_DEPTH = c_CNTW'(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_PTRW-1:0] r_wr_ptr;
    logic [c_PTRW-1:0] r_rd_ptr;
    logic [c_CNTW-1:0] r_count;
    logic              w_pop;
    logic              w_push;

    assign w_pop  = i_rd_en && (r_count != '0);
    // A write into a full FIFO is only taken when the head leaves in the same cycle.
    assign w_push = i_wr_en && ((r_count != c_DEPTH) || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid   = (r_count != '0);
    assign o_rd_data = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/avalon_master_adapter.sv
// +------------------------------------------------------------------+
// | avalon_master_adapter: valid/ready command stream to Avalon-MM     |
// | master with credit-limited pipelined reads.                        |
// | Optional: AVM_MASTER_TIMEOUT_EN adds a waitrequest timeout abort.  |
// |                                                    Rev 1.0        |
// +------------------------------------------------------------------+
`default_nettype none

module avalon_master_adapter
    import avalon_master_pkg::*;
#(
    parameter int ADDRESSWIDTH    = c_DEF_ADDRESSWIDTH,
    parameter int BUSWIDTH        = c_DEF_BUSWIDTH,
    parameter int MAX_OUTSTANDING = c_DEF_MAX_OUTSTANDING,
`ifdef AVM_MASTER_TIMEOUT_EN
    parameter int TIMEOUT         = c_DEF_TIMEOUT,
`endif
    parameter int CNTWIDTH        = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESSWIDTH-1:0] cmd_address,
    input  logic [BUSWIDTH-1:0]     cmd_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [BUSWIDTH-1:0]     rsp_data,
    output logic                    avm_read,
    output logic                    avm_write,
    output logic [ADDRESSWIDTH-1:0] avm_address,
    output logic [BUSWIDTH-1:0]     avm_writedata,
    input  logic                    avm_waitrequest,
    input  logic                    avm_readdatavalid,
    input  logic [BUSWIDTH-1:0]     avm_readdata,
    output logic                    busy
`ifdef AVM_MASTER_TIMEOUT_EN
    ,
    output logic                    timeout_err
`endif
);

    localparam logic [CNTWIDTH-1:0] c_MAX_CREDITS = CNTWIDTH'(MAX_OUTSTANDING);

    state_t              r_state;
    state_t              w_state_next;
    logic [CNTWIDTH-1:0] r_credits;

    logic w_complete;
    logic w_accept;
    logic w_rd_accept;
    logic w_pop;
    logic w_abort;
    logic w_abort_rd;
    logic w_fifo_wr;

    assign w_complete  = (r_state == ISSUE) && !avm_waitrequest;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_rd_accept = w_accept && !cmd_write;
    assign w_pop       = rsp_valid && rsp_ready;
    assign w_abort_rd  = w_abort && avm_read;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (w_complete) begin
                    w_state_next = w_accept ? ISSUE : IDLE;
                end else if (w_abort) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output logic: the bus slot frees in the same cycle the slave drops waitrequest.
    always_comb begin
        cmd_ready = ((r_state == IDLE) || !avm_waitrequest)
                  && (cmd_write || (r_credits < c_MAX_CREDITS));
        busy      = (r_state == ISSUE) || (r_credits != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else if (w_accept) begin
            avm_read      <= !cmd_write;
            avm_write     <= cmd_write;
            avm_address   <= cmd_address;
            avm_writedata <= cmd_data;
        end else if (w_complete || w_abort) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
        end
    end

    // A read credit lives from command accept until its response is popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_credits <= '0;
        end else begin
            r_credits <= r_credits + CNTWIDTH'(w_rd_accept)
                       - CNTWIDTH'(w_pop) - CNTWIDTH'(w_abort_rd);
        end
    end

`ifdef AVM_MASTER_TIMEOUT_EN
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] r_stall_cnt;

    assign w_abort = (r_state == ISSUE) && avm_waitrequest
                   && (r_stall_cnt == c_TIMEOUT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((r_state == ISSUE) && avm_waitrequest && !w_abort) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end else begin
                r_stall_cnt <= '0;
            end
            if (w_abort) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    // Stray return data with no credit held (e.g. after a reset) is dropped.
    assign w_fifo_wr = avm_readdatavalid && (r_credits != '0);

    sync_fifo #(
        .WIDTH (BUSWIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (avm_readdata),
        .i_rd_en   (w_pop),
        .o_valid   (rsp_valid),
        .o_rd_data (rsp_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_avalon_master_adapter.sv
// +------------------------------------------------------------------+
// | tb_avalon_master_adapter: self-checking bench for the Avalon-MM   |
// | master adapter.                                    Rev 1.0        |
// +------------------------------------------------------------------+
`default_nettype none

module tb_avalon_master_adapter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_address;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          avm_read, avm_write;
    logic [AW-1:0] avm_address;
    logic [DW-1:0] avm_writedata;
    logic          avm_waitrequest, avm_readdatavalid;
    logic [DW-1:0] avm_readdata;
    logic          busy;
`ifdef AVM_MASTER_TIMEOUT_EN
    logic          timeout_err;
`endif

    always #5 clk = ~clk;

    avalon_master_adapter #(
        .ADDRESSWIDTH    (AW),
        .BUSWIDTH        (DW),
        .MAX_OUTSTANDING (MAXO)
`ifdef AVM_MASTER_TIMEOUT_EN
        , .TIMEOUT       (8)
`endif
    ) u_dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_address       (cmd_address),
        .cmd_data          (cmd_data),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (rsp_data),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_address       (avm_address),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_readdata      (avm_readdata),
        .busy              (busy)
`ifdef AVM_MASTER_TIMEOUT_EN
        , .timeout_err     (timeout_err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: bus slot, credits, returned data count.
    // Read data returned by the bench slave is the running return index,
    // so the n-th popped response must equal n.
    bit            m_onbus, m_is_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int            m_credits, m_pending, m_fifo, m_rets, m_pops, m_stall;
    int            n_dut_pops;

    task automatic model_clear();
        m_onbus = 1'b0; m_is_write = 1'b0; m_addr = '0; m_wdata = '0;
        m_credits = 0; m_pending = 0; m_fifo = 0; m_rets = 0; m_pops = 0;
        m_stall = 0; n_dut_pops = 0;
    endtask

    task automatic drive_idle();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_data = '0;
        rsp_ready = 1'b0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        avm_readdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    // One clock of stimulus, checked against the reference; acc reports DUT acceptance.
    task automatic step(input bit cv, input bit cw, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit wr, input bit rdv_req,
                        input bit rr, output bit acc);
        bit exp_ready, rdv, comp, pop, macc;
        rdv = rdv_req && (m_pending > 0);
        cmd_valid = cv; cmd_write = cw; cmd_address = a; cmd_data = d;
        avm_waitrequest = wr; avm_readdatavalid = rdv;
        avm_readdata = 32'(m_rets);
        rsp_ready = rr;
        #1;
        exp_ready = (!m_onbus || !wr) && (cw || (m_credits < MAXO));
        check("cmd_ready", cmd_ready, exp_ready);
        check("busy", busy, m_onbus || (m_credits != 0));
        check("avm_read", avm_read, m_onbus && !m_is_write);
        check("avm_write", avm_write, m_onbus && m_is_write);
        if (m_onbus) begin
            check("avm_address", avm_address, m_addr);
            if (m_is_write) check("avm_writedata", avm_writedata, m_wdata);
        end
        check("rsp_valid", rsp_valid, m_fifo > 0);
        if (m_fifo > 0) check("rsp_data_order", rsp_data, 32'(m_pops));
        acc  = cv && cmd_ready;
        macc = cv && exp_ready;
        comp = m_onbus && !wr;
        pop  = rr && (m_fifo > 0);
        if (rsp_valid && rr) n_dut_pops++;
        @(posedge clk);
        #1;
        m_stall = (m_onbus && wr && !macc) ? m_stall + 1 : 0;
        if (comp && !m_is_write) m_pending++;
        if (rdv) begin m_fifo++; m_rets++; m_pending--; end
        if (pop) begin m_fifo--; m_pops++; m_credits--; end
        if (macc && !cw) m_credits++;
        if (macc) begin
            m_onbus = 1'b1; m_is_write = cw; m_addr = a; m_wdata = d;
        end else if (comp) begin
            m_onbus = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        bit acc;
        int cyc = 0;
        while ((m_onbus || m_credits != 0) && cyc < 200) begin
            step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
            cyc++;
        end
        check({tag, "_drain_bound"}, 32'(cyc < 200), 32'd1);
        check({tag, "_drain_busy"}, busy, 1'b0);
        check({tag, "_drain_rspv"}, rsp_valid, 1'b0);
    endtask

    typedef struct {
        bit            cv, cw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            wr, rdv;
        logic [DW-1:0] rdata;
        bit            rr;
        bit            e_ready, e_read, e_write, e_busy, e_rspv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [DW-1:0] e_rsp;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc, cv_r, cw_r, wr_r, rdv_r, rr_r;
        int n_acc, issued, n_hi;

        // Single write, then read with 3 wait states and 2-cycle return latency, then back-to-back writes.
        vecs[0]  = '{1'b1,1'b1,16'h0010,32'hDEADBEEF,1'b0,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,16'h0,32'h0,32'h0};
        vecs[1]  = '{1'b0,1'b0,16'h0000,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0,16'h0010,32'hDEADBEEF,32'h0};
        vecs[2]  = '{1'b0,1'b0,16'h0000,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,16'h0,32'h0,32'h0};
        vecs[3]  = '{1'b1,1'b0,16'h0004,32'h0,1'b1,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,16'h0,32'h0,32'h0};
        vecs[4]  = '{1'b0,1'b0,16'h0000,32'h0,1'b1,1'b0,32'h0,1'b0, 1'b0,1'b1,1'b0,1'b1,1'b0,16'h0004,32'h0,32'h0};
        vecs[5]  = vecs[4];
        vecs[6]  = vecs[4];
        vecs[7]  = '{1'b0,1'b0,16'h0000,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,1'b1,1'b0,1'b1,1'b0,16'h0004,32'h0,32'h0};
        vecs[8]  = '{1'b0,1'b0,16'h0000,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,16'h0,32'h0,32'h0};
        vecs[9]  = '{1'b0,1'b0,16'h0000,32'h0,1'b0,1'b1,32'h12345678,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,16'h0,32'h0,32'h0};
        vecs[10] = '{1'b0,1'b0,16'h0000,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1,16'h0,32'h0,32'h12345678};
        vecs[11] = '{1'b0,1'b0,16'h0000,32'h0,1'b0,1'b0,32'h0,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b1,16'h0,32'h0,32'h12345678};
        vecs[12] = '{1'b1,1'b1,16'h0020,32'h1,1'b0,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,16'h0,32'h0,32'h0};
        vecs[13] = '{1'b1,1'b1,16'h0021,32'h2,1'b1,1'b0,32'h0,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0,16'h0020,32'h1,32'h0};
        vecs[14] = '{1'b1,1'b1,16'h0021,32'h2,1'b0,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0,16'h0020,32'h1,32'h0};
        vecs[15] = '{1'b0,1'b0,16'h0000,32'h0,1'b0,1'b0,32'h0,1'b0, 1'b1,1'b0,1'b1,1'b1,1'b0,16'h0021,32'h2,32'h0};
        vecs[16] = vecs[2];

        reset = 1'b1;
        drive_idle();
        model_clear();
        @(posedge clk);
        #1;
        check("rst_avm_read", avm_read, 1'b0);
        check("rst_avm_write", avm_write, 1'b0);
        check("rst_avm_address", avm_address, '0);
        check("rst_avm_writedata", avm_writedata, '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_busy", busy, 1'b0);
`ifdef AVM_MASTER_TIMEOUT_EN
        check("rst_timeout_err", timeout_err, 1'b0);
`endif

        do_reset();
        foreach (vecs[i]) begin
            cmd_valid = vecs[i].cv; cmd_write = vecs[i].cw;
            cmd_address = vecs[i].addr; cmd_data = vecs[i].data;
            avm_waitrequest = vecs[i].wr; avm_readdatavalid = vecs[i].rdv;
            avm_readdata = vecs[i].rdata; rsp_ready = vecs[i].rr;
            #1;
            check($sformatf("vec%0d_ready", i), cmd_ready, vecs[i].e_ready);
            check($sformatf("vec%0d_read", i), avm_read, vecs[i].e_read);
            check($sformatf("vec%0d_write", i), avm_write, vecs[i].e_write);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d_rspv", i), rsp_valid, vecs[i].e_rspv);
            if (vecs[i].e_read || vecs[i].e_write)
                check($sformatf("vec%0d_addr", i), avm_address, vecs[i].e_addr);
            if (vecs[i].e_write)
                check($sformatf("vec%0d_wdata", i), avm_writedata, vecs[i].e_wdata);
            if (vecs[i].e_rspv)
                check($sformatf("vec%0d_rsp", i), rsp_data, vecs[i].e_rsp);
            @(posedge clk);
            #1;
        end

        // Credit limit: reads stall at MAX_OUTSTANDING, writes still pass.
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 16'(16'h0100 + i), '0, 1'b0, 1'b0, 1'b0, acc);
            if (acc) n_acc++;
        end
        check("credit_limit_accepts", 32'(n_acc), 32'd4);
        step(1'b1, 1'b1, 16'h0040, 32'hCAFE0001, 1'b0, 1'b0, 1'b0, acc);
        check("write_at_limit", acc, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 1'b0, 16'h0200, '0, 1'b0, 1'b0, 1'b0, acc);
        check("ready_full_no_pop", acc, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 1'b0, 16'h0201, '0, 1'b0, 1'b0, 1'b0, acc);
        check("ready_after_pop", acc, 1'b1);
        drain("credit");

        // Ordering and pointer wrap: 10 pipelined reads, random back-pressure.
        do_reset();
        issued = 0;
        for (int cyc = 0; cyc < 400 && n_dut_pops < 10; cyc++) begin
            wr_r  = (m_stall < 4) && ($urandom_range(0, 3) == 0);
            rdv_r = ($urandom_range(0, 1) == 1);
            rr_r  = ($urandom_range(0, 1) == 1);
            step(issued < 10, 1'b0, 16'(16'h0300 + issued), '0, wr_r, rdv_r, rr_r, acc);
            if (acc) issued++;
        end
        check("order_issued", 32'(issued), 32'd10);
        check("order_pop_count", 32'(n_dut_pops), 32'd10);
        drain("order");

        // Fully random traffic.
        do_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            cv_r  = ($urandom_range(0, 1) == 1);
            cw_r  = ($urandom_range(0, 2) == 0);
            wr_r  = (m_stall < 4) && ($urandom_range(0, 3) == 0);
            rdv_r = ($urandom_range(0, 1) == 1);
            rr_r  = ($urandom_range(0, 2) != 0);
            step(cv_r, cw_r, 16'($urandom), 32'($urandom), wr_r, rdv_r, rr_r, acc);
        end
        drain("random");

        // Reset while a read is stalled on the bus.
        do_reset();
        step(1'b1, 1'b0, 16'h0ABC, '0, 1'b1, 1'b0, 1'b0, acc);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
        avm_waitrequest = 1'b1;
        reset = 1'b1;
        #1;
        check("midrst_avm_read", avm_read, 1'b0);
        check("midrst_avm_write", avm_write, 1'b0);
        check("midrst_avm_address", avm_address, '0);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_rsp_data", rsp_data, '0);
        check("midrst_busy", busy, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'h5A5A5A5A;
        @(posedge clk);
        #1 avm_readdatavalid = 1'b0;
        #1;
        check("midrst_late_rdv_dropped", rsp_valid, 1'b0);
        check("midrst_late_busy", busy, 1'b0);

`ifdef AVM_MASTER_TIMEOUT_EN
        do_reset();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 16'h0077;
        avm_waitrequest = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n_hi = 0;
        while (avm_read && n_hi < 40) begin
            n_hi++;
            @(posedge clk);
            #1;
        end
        check("timeout_read_cycles", 32'(n_hi), 32'd8);
        check("timeout_err", timeout_err, 1'b1);
        check("timeout_busy", busy, 1'b0);
        check("timeout_ready", cmd_ready, 1'b1);
`else
        n_hi = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
